// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue
//  Purpose  : Fetch PC owner, ROM address driver and prefetch FIFO feeding
//             the decoder; redirects flush the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [31:0]                rom_addr,
    input  logic [31:0]                rom_data,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       inst_valid,
    output logic [31:0]                inst_data,
    output logic [31:0]                inst_pc,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_AW-1:0] c_PTR_ONE = 1;
    localparam logic [c_CW-1:0] c_CNT_ONE = 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEPTH);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;

    logic w_pop;
    logic w_push;
    logic w_unused_pc_lsbs;

    assign inst_valid  = (r_count != '0);
    assign inst_data   = r_mem_instr[r_rd_ptr];
    assign inst_pc     = r_mem_pc[r_rd_ptr];
    assign queue_count = r_count;
    assign rom_addr    = r_fetch_pc;

    assign w_pop  = inst_valid & inst_ready;
    // A full queue may still accept a fetch when the head leaves this cycle.
    assign w_push = ~redirect_valid & ((r_count < c_CNT_MAX) | w_pop);

    assign w_unused_pc_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Flush wins over any concurrent pop or fetch.
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
                r_mem_instr[r_wr_ptr] <= rom_data;
                r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
                r_fetch_pc            <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_queue
//  Purpose  : Directed vector bench for instr_fetch_queue with a ROM model
//             returning word index + 1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [2:0]  queue_count;

    int n_total;
    int n_pass;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .queue_count    (queue_count)
    );

    // ROM word[i] = i + 1
    assign rom_data = {2'b00, rom_addr[31:2]} + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] edata;
        logic [31:0] ecnt;
        logic [31:0] erom;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [31:0] edata,
                       input logic [31:0] ecnt, input logic [31:0] erom);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
        v.epc = epc; v.edata = edata; v.ecnt = ecnt; v.erom = erom;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [31:0] epc,
                                 input logic [31:0] edata, input logic [31:0] ecnt,
                                 input logic [31:0] erom);
        check({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, ev});
        check({tag, " queue_count"}, {29'd0, queue_count}, ecnt);
        check({tag, " rom_addr"}, rom_addr, erom);
        if (ev) begin
            check({tag, " inst_pc"}, inst_pc, epc);
            check({tag, " inst_data"}, inst_data, edata);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        // rv rpc rdy | valid pc data count rom_addr  (sampled after the edge)
        add(0, 0, 1, 1, 32'h0,  1, 1, 32'h4);
        add(0, 0, 1, 1, 32'h4,  2, 1, 32'h8);
        add(0, 0, 1, 1, 32'h8,  3, 1, 32'hC);
        add(0, 0, 1, 1, 32'hC,  4, 1, 32'h10);
        add(0, 0, 0, 1, 32'hC,  4, 2, 32'h14);
        add(0, 0, 0, 1, 32'hC,  4, 3, 32'h18);
        add(0, 0, 0, 1, 32'hC,  4, 4, 32'h1C);
        add(0, 0, 0, 1, 32'hC,  4, 4, 32'h1C);
        add(0, 0, 0, 1, 32'hC,  4, 4, 32'h1C);
        add(0, 0, 1, 1, 32'h10, 5, 4, 32'h20);
        add(0, 0, 0, 1, 32'h10, 5, 4, 32'h20);
        add(1, 32'h0000_0103, 0, 0, 0, 0, 0, 32'h100);
        add(0, 0, 0, 1, 32'h100, 65, 1, 32'h104);
        add(0, 0, 0, 1, 32'h100, 65, 2, 32'h108);
        add(0, 0, 0, 1, 32'h100, 65, 3, 32'h10C);
        add(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
        add(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h4000_0000, 1, 32'h0);
        add(0, 0, 1, 1, 32'h0, 1, 1, 32'h4);
        add(0, 0, 1, 1, 32'h4, 2, 1, 32'h8);
        add(0, 0, 0, 1, 32'h4, 2, 2, 32'hC);

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        #2;
        check_outputs("reset", 1'b0, 0, 0, 0, 32'h0);
        check("reset inst_pc", inst_pc, 32'h0);
        check("reset inst_data", inst_data, 32'h0);
        #5;
        reset = 1'b0;

        foreach (vecs[i]) begin
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            inst_ready     = vecs[i].rdy;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc,
                          vecs[i].edata, vecs[i].ecnt, vecs[i].erom);
        end

        // Asynchronous reset mid-cycle with two entries queued.
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 1'b0, 0, 0, 0, 32'h0);
        check("async_reset inst_pc", inst_pc, 32'h0);
        #2;
        reset      = 1'b0;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_reset", 1'b1, 32'h0, 1, 1, 32'h4);
        @(posedge clk);
        #1;
        check_outputs("post_reset2", 1'b1, 32'h4, 2, 1, 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
